psum_writeback_ctrl: RTL and testbench
======================================

// Module: psum_writeback_ctrl
// PURPOSE
//  Write-buffer controller directly downstream of the main controller.
//  - Captures each finished partial sum when the main controller pulses `done` (WRITE_REQ).
//  - Queues it in a small output FIFO drained by a valid/ready sink.
//  - Returns the 2-bit `stall` code that the main controller polls in WAIT_FOR_WRITE:
//    00 = keep waiting, 10 = add next, 11 = all outputs written / stall.
// PARAMETERS
//  DATA_WIDTH  16  width of one partial sum
//  DEPTH       4   output FIFO entries (power of two, >=2)
//  CNT_WIDTH   8   width of output counter and total_outputs
// PORTS
//  clk            in   1           clock; all state changes on posedge
//  reset          in   1           synchronous, active-high reset
//  chip_en        in   1           0 freezes FSM and counter; FIFO drain unaffected
//  done           in   1           one-cycle write request from main controller
//  psum_in        in   DATA_WIDTH  partial sum, valid in the cycle done=1
//  total_outputs  in   CNT_WIDTH   outputs expected this run; static while busy
//  out_ready      in   1           sink accepts out_data
//  out_valid      out  1           FIFO non-empty
//  out_data       out  DATA_WIDTH  FIFO head
//  stall          out  2           00 wait / 10 add next / 11 finished
//  error          out  1           sticky protocol error
//  fifo_level     out  clog2(DEPTH)+1  current FIFO occupancy
//  written_cnt    out  CNT_WIDTH   psums pushed since reset
// BEHAVIOUR
//  Reset (sync): every output is 0, the FIFO is empty, and the FSM goes to IDLE.
//  Reset overrides everything, including mid-transfer; the held word is discarded.
//  FSM states: IDLE, PUSH, REPORT, FINISHED, ERR. The FSM advances only when chip_en=1.
//  IDLE:
//   - done=1: hold <= psum_in; go to PUSH.
//  PUSH:
//   - push_ok = (fifo_level<DEPTH) | (out_valid & out_ready).
//   - push_ok=1: write hold to FIFO tail and go to REPORT.
//   - push_ok=0: stay in PUSH; stall stays 00.
//  REPORT:
//   - written_cnt <= written_cnt+1.
//   - If written_cnt+1 >= total_outputs, go to FINISHED; otherwise go to IDLE.
//   - stall=10 only when returning to IDLE.
//   - total_outputs=0 therefore finishes on the first write.
//  FINISHED:
//   - stall=11, held until reset.
//   - Further done pulses are ignored; they are not errors.
//  ERR:
//   - Entered on done=1 while in PUSH or REPORT.
//   - error=1 and stall=00 until reset; the held word is kept but never pushed.
//  stall is a registered-state decode; it is 00 in IDLE, PUSH and ERR.
//  Latency (FIFO not full):
//   - done in cycle t -> push in t+1 -> stall=10 in t+2 -> stall=00 in t+3.
//  FIFO:
//   - Circular buffer; read/write pointers wrap modulo DEPTH.
//   - Pop when out_valid & out_ready.
//   - Simultaneous push and pop: level unchanged; a push while full is accepted only with a same-cycle pop.
//   - Pop on empty is impossible because out_valid=0.
//   - out_data is the head entry, valid whenever out_valid=1.
//  written_cnt saturates at all-ones and does not wrap.
//  chip_en=0: FSM state, hold and written_cnt freeze; a done pulse is lost; the FIFO still pops.
// TESTING
//  T1 single write:
//   - total_outputs=3, out_ready=1, done with psum_in=0x0012.
//   - Expect stall=10 two cycles later for one cycle, then out_data=0x0012 with out_valid, written_cnt=1.
//  T2 completion:
//   - total_outputs=3, three done pulses spaced 4 cycles apart.
//   - Expect stall 10,10 after the first two, then 11 held; a 4th done is ignored and error stays 0.
//  T3 backpressure:
//   - DEPTH=4, out_ready=0, five writes.
//   - Expect fifo_level=4 and the FSM stuck in PUSH with stall=00.
//   - Raising out_ready pushes the 5th word the same cycle the 1st pops.
//   - Data order in 1..5, level ends 0.
//  T4 protocol error:
//   - done asserted in consecutive cycles.
//   - Expect error=1 and stall=00 persisting; reset clears both to 0.
//  T5 reset mid-operation:
//   - reset during PUSH with 2 queued words.
//   - Next cycle expect out_valid=0, fifo_level=0, written_cnt=0, stall=00.
//  T6 chip_en gating:
//   - chip_en=0 in the cycle after done.
//   - Expect no push while chip_en=0 and the FIFO still drains; the push completes after chip_en returns to 1.

Source files
------------

// File: rtl/psum_writeback_ctrl.sv
// Captures finished partial sums, queues them in a small FIFO for a valid/ready sink,
// and reports the write-back handshake code back to the main controller.
module psum_writeback_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   chip_en,
  input  logic                   done,
  input  logic [DATA_WIDTH-1:0]  psum_in,
  input  logic [CNT_WIDTH-1:0]   total_outputs,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [1:0]             stall,
  output logic                   error,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_WIDTH-1:0]   written_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [2:0] {IDLE, PUSH, REPORT, FINISHED, ERR} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  pop, push_ok, push, last;
  logic [CNT_WIDTH-1:0]  cnt_next;

  assign out_valid = (fifo_level != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign pop       = out_valid & out_ready;
  // A full FIFO still takes the word if the head leaves in the same cycle.
  assign push_ok   = (fifo_level < LW'(DEPTH)) | pop;
  assign push      = chip_en & (state == PUSH) & ~done & push_ok;
  assign cnt_next  = (&written_cnt) ? written_cnt : written_cnt + CNT_WIDTH'(1);
  assign last      = (cnt_next >= total_outputs);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= hold;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // The stall code is decided one state early so it is registered when REPORT is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hold        <= '0;
      written_cnt <= '0;
      stall       <= 2'b00;
      error       <= 1'b0;
    end else if (chip_en) begin
      case (state)
        IDLE: begin
          if (done) begin
            hold  <= psum_in;
            state <= PUSH;
          end
        end
        PUSH: begin
          if (done) begin
            state <= ERR;
            error <= 1'b1;
            stall <= 2'b00;
          end else if (push_ok) begin
            state <= REPORT;
            stall <= last ? 2'b11 : 2'b10;
          end
        end
        REPORT: begin
          if (done) begin
            state <= ERR;
            error <= 1'b1;
            stall <= 2'b00;
          end else begin
            written_cnt <= cnt_next;
            state       <= last ? FINISHED : IDLE;
            stall       <= last ? 2'b11 : 2'b00;
          end
        end
        FINISHED: stall <= 2'b11;
        ERR:      stall <= 2'b00;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_writeback_ctrl.sv
// Directed bench for psum_writeback_ctrl with a data scoreboard on the sink side.
module tb_psum_writeback_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chip_en = 1'b1;
  logic        done = 1'b0;
  logic [15:0] psum_in = '0;
  logic [7:0]  total_outputs = 8'd3;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  stall;
  logic        error;
  logic [2:0]  fifo_level;
  logic [7:0]  written_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];

  psum_writeback_ctrl #(.DATA_WIDTH(16), .DEPTH(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .chip_en(chip_en), .done(done), .psum_in(psum_in),
    .total_outputs(total_outputs), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .stall(stall), .error(error), .fifo_level(fifo_level),
    .written_cnt(written_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one done pulse; returns one cycle later (FSM now in PUSH if it was IDLE).
  task automatic write(input logic [15:0] d, input bit expect_push);
    done    = 1'b1;
    psum_in = d;
    if (expect_push) exp_q.push_back(d);
    cyc();
    done    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Sink-side scoreboard: a pop happens at the next posedge whenever valid&ready here.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL pop_unexpected observed=%0h expected=none", out_data);
      end
      if (exp_q.size() > 0) chk("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    cyc(2);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_cnt",   32'(written_cnt), 32'd0);
    chk("rst_data",  32'(out_data), 32'd0);
    reset = 1'b0;
    cyc();

    // T1 single write
    total_outputs = 8'd3;
    out_ready     = 1'b1;
    write(16'h0012, 1'b1);
    chk("t1_stall_t1", 32'(stall), 32'd0);
    cyc();
    chk("t1_stall_t2", 32'(stall), 32'd2);
    chk("t1_valid",    32'(out_valid), 32'd1);
    chk("t1_data",     32'(out_data), 32'h0012);
    cyc();
    chk("t1_stall_t3", 32'(stall), 32'd0);
    chk("t1_cnt",      32'(written_cnt), 32'd1);

    // T2 completion
    do_reset();
    for (int i = 0; i < 3; i++) begin
      write(16'h0100 + 16'(i), 1'b1);
      cyc();
      chk("t2_stall", 32'(stall), (i < 2) ? 32'd2 : 32'd3);
      cyc(2);
    end
    chk("t2_finished", 32'(stall), 32'd3);
    write(16'h0BAD, 1'b0);
    cyc(3);
    chk("t2_stall_held", 32'(stall), 32'd3);
    chk("t2_no_error",   32'(error), 32'd0);
    chk("t2_cnt",        32'(written_cnt), 32'd3);
    chk("t2_level",      32'(fifo_level), 32'd0);

    // T3 backpressure
    do_reset();
    total_outputs = 8'd8;
    out_ready     = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      write(16'(i), 1'b1);
      cyc(2);
    end
    chk("t3_full", 32'(fifo_level), 32'd4);
    write(16'd5, 1'b1);
    cyc(3);
    chk("t3_stuck_level", 32'(fifo_level), 32'd4);
    chk("t3_stuck_stall", 32'(stall), 32'd0);
    chk("t3_stuck_cnt",   32'(written_cnt), 32'd4);
    out_ready = 1'b1;
    cyc();
    chk("t3_swap_level", 32'(fifo_level), 32'd4);
    chk("t3_swap_stall", 32'(stall), 32'd2);
    cyc(8);
    chk("t3_drained", 32'(fifo_level), 32'd0);
    chk("t3_cnt",     32'(written_cnt), 32'd5);

    // T4 protocol error: the second pulse lands while in PUSH
    do_reset();
    write(16'h00AA, 1'b0);
    write(16'h00BB, 1'b0);
    cyc(3);
    chk("t4_error", 32'(error), 32'd1);
    chk("t4_stall", 32'(stall), 32'd0);
    chk("t4_level", 32'(fifo_level), 32'd0);
    cyc(3);
    chk("t4_error_sticky", 32'(error), 32'd1);
    do_reset();
    chk("t4_rst_error", 32'(error), 32'd0);
    chk("t4_rst_stall", 32'(stall), 32'd0);

    // T5 reset while in PUSH with two queued words
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      write(16'h0A00 + 16'(i), 1'b1);
      cyc(2);
    end
    chk("t5_pre_level", 32'(fifo_level), 32'd2);
    write(16'h0A02, 1'b1);
    do_reset();
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_level", 32'(fifo_level), 32'd0);
    chk("t5_cnt",   32'(written_cnt), 32'd0);
    chk("t5_stall", 32'(stall), 32'd0);

    // T6 chip_en gating: FSM frozen in PUSH, FIFO still drains
    write(16'h0055, 1'b1);
    cyc(2);
    write(16'h0066, 1'b1);
    chip_en   = 1'b0;
    out_ready = 1'b1;
    cyc(3);
    chk("t6_drain_level", 32'(fifo_level), 32'd0);
    chk("t6_frozen_cnt",  32'(written_cnt), 32'd1);
    chk("t6_frozen_stall", 32'(stall), 32'd0);
    chip_en = 1'b1;
    cyc();
    chk("t6_resume_stall", 32'(stall), 32'd2);
    chk("t6_resume_valid", 32'(out_valid), 32'd1);
    cyc(3);
    chk("t6_cnt",   32'(written_cnt), 32'd2);
    chk("t6_level", 32'(fifo_level), 32'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
